// File: rtl/core_pkg.sv
// Shared core definitions: register address width, NOP encoding used by the
// pipeline flush consumers, and the hazard controller state encoding.
package core_pkg;

    // Architectural register address width (x0..x31).
    localparam int REG_AW = 5;

    // Canonical RV32I NOP (addi x0, x0, 0) loaded into a flushed stage register.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Hazard controller states: IDLE watches for load-use dependences,
    // WAIT holds the pipeline for the remaining bubbles of a multi-cycle load.
    typedef enum logic [0:0] {
        HZ_IDLE = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_e;

endpackage : core_pkg

// File: rtl/hazard_detect_cmp.sv
// Pure combinational load-use dependence comparator. A dependence exists when
// the EX-stage load writes a non-zero register that a used ID source reads.
// Kept standalone so the forwarding unit can reuse the same comparison.
module hazard_detect_cmp #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          rs1_used,
    input  logic          rs2_used,
    input  logic [AW-1:0] rd,
    input  logic          mem_read,
    output logic          hit
);

    logic rd_nonzero_s;
    logic rs1_match_s;
    logic rs2_match_s;

    // x0 is hardwired to zero, so a load targeting it never creates a dependence.
    assign rd_nonzero_s = (rd != {AW{1'b0}});
    assign rs1_match_s  = rs1_used && (rd == rs1);
    assign rs2_match_s  = rs2_used && (rd == rs2);

    assign hit = mem_read && rd_nonzero_s && (rs1_match_s || rs2_match_s);

endmodule : hazard_detect_cmp

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use dependences, holds the front of
// the pipeline for LOAD_LAT bubbles per hazard, merges EX-stage redirect
// flushes, and counts inserted bubbles with a saturating counter.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_rs1_used,
    input  logic              if_id_rs2_used,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              ex_redirect,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              busy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import core_pkg::*;

    // Down-counter wide enough to hold LOAD_LAT-1 (and 0 when LOAD_LAT is 1).
    localparam int               REM_W    = $clog2(LOAD_LAT + 1);
    localparam logic [REM_W-1:0] REM_ZERO = REM_W'(0);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [REM_W-1:0] remaining_q;
    logic [REM_W-1:0] remaining_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    logic detect_s;
    logic bubble_s;
    logic in_wait_s;

    hazard_detect_cmp #(
        .AW(REG_AW)
    ) u_cmp (
        .rs1      (if_id_rs1),
        .rs2      (if_id_rs2),
        .rs1_used (if_id_rs1_used),
        .rs2_used (if_id_rs2_used),
        .rd       (id_ex_rd),
        .mem_read (id_ex_mem_read),
        .hit      (detect_s)
    );

    assign in_wait_s = (state_q == HZ_WAIT);

    // Next-state, bubble decision and counter update; redirect wins over any stall.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        bubble_s     = 1'b0;
        bubble_cnt_d = bubble_cnt_q;

        if (ex_redirect) begin
            // The dependent consumer is being squashed: abandon any stall.
            state_d     = HZ_IDLE;
            remaining_d = REM_ZERO;
        end else begin
            case (state_q)
                HZ_IDLE: begin
                    if (detect_s) begin
                        bubble_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d     = HZ_WAIT;
                            remaining_d = REM_INIT;
                        end else begin
                            state_d     = HZ_IDLE;
                            remaining_d = REM_ZERO;
                        end
                    end else begin
                        state_d     = HZ_IDLE;
                        remaining_d = REM_ZERO;
                    end
                end
                HZ_WAIT: begin
                    // ID/EX already holds a bubble here, so detect cannot re-trigger.
                    bubble_s = 1'b1;
                    if (remaining_q <= REM_ONE) begin
                        state_d     = HZ_IDLE;
                        remaining_d = REM_ZERO;
                    end else begin
                        state_d     = HZ_WAIT;
                        remaining_d = remaining_q - REM_ONE;
                    end
                end
                default: begin
                    state_d     = HZ_IDLE;
                    remaining_d = REM_ZERO;
                end
            endcase
        end

        // Saturate rather than wrap so long runs never under-report stalls.
        if (bubble_s && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // State, bubble down-counter and performance counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= HZ_IDLE;
            remaining_q  <= REM_ZERO;
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Control outputs act in the same cycle as the hazard; gated by rstn so a
    // core held in reset never sees a stall or flush request.
    assign stall_pc    = rstn && bubble_s;
    assign stall_if_id = rstn && bubble_s;
    assign flush_if_id = rstn && ex_redirect;
    assign flush_id_ex = rstn && (bubble_s || ex_redirect);
    assign busy        = rstn && in_wait_s;
    assign bubble_cnt  = bubble_cnt_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT 1, 3 and 2 with a 4-bit
// counter) share one stimulus stream; a bubble-budget model checks every cycle.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, redir;

    logic [2:0]  st_pc, st_ifid, fl_ifid, fl_idex, bz;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;
    int          cnt_a [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: bubbles still owed per instance and bubbles counted so far.
    int lat  [3] = '{1, 3, 2};
    int cmax [3] = '{65535, 65535, 15};
    int left [3] = '{0, 0, 0};
    int mcnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rstn(rstn), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd),
        .id_ex_mem_read(mr), .ex_redirect(redir),
        .stall_pc(st_pc[0]), .stall_if_id(st_ifid[0]), .flush_if_id(fl_ifid[0]),
        .flush_id_ex(fl_idex[0]), .busy(bz[0]), .bubble_cnt(cnt0));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rstn(rstn), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd),
        .id_ex_mem_read(mr), .ex_redirect(redir),
        .stall_pc(st_pc[1]), .stall_if_id(st_ifid[1]), .flush_if_id(fl_ifid[1]),
        .flush_id_ex(fl_idex[1]), .busy(bz[1]), .bubble_cnt(cnt1));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(4)) u_l2c4 (
        .clk(clk), .rstn(rstn), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_rs1_used(u1), .if_id_rs2_used(u2), .id_ex_rd(rd),
        .id_ex_mem_read(mr), .ex_redirect(redir),
        .stall_pc(st_pc[2]), .stall_if_id(st_ifid[2]), .flush_if_id(fl_ifid[2]),
        .flush_id_ex(fl_idex[2]), .busy(bz[2]), .bubble_cnt(cnt2));

    assign cnt_a[0] = int'(cnt0);
    assign cnt_a[1] = int'(cnt1);
    assign cnt_a[2] = int'(cnt2);

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[inst%0d] @%0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the bubble-budget model, away from posedge.
    always @(negedge clk) begin
        bit det;
        bit bump;
        int e_st, e_fi, e_fe, e_bz;
        det = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        for (int k = 0; k < 3; k++) begin
            bump = 1'b0;
            e_st = 0; e_fi = 0; e_fe = 0; e_bz = 0;
            if (!rstn) begin
                left[k] = 0;
                mcnt[k] = 0;
            end else begin
                e_bz = (left[k] > 0) ? 1 : 0;
                if (redir) begin
                    e_fi = 1;
                    e_fe = 1;
                    left[k] = 0;
                end else begin
                    if (left[k] == 0 && det) left[k] = lat[k];
                    if (left[k] > 0) begin
                        e_st = 1;
                        e_fe = 1;
                        left[k] = left[k] - 1;
                        bump = 1'b1;
                    end
                end
            end
            chk("stall_pc",    k, int'(st_pc[k]),   e_st);
            chk("stall_if_id", k, int'(st_ifid[k]), e_st);
            chk("flush_if_id", k, int'(fl_ifid[k]), e_fi);
            chk("flush_id_ex", k, int'(fl_idex[k]), e_fe);
            if (!(rstn && redir)) chk("busy", k, int'(bz[k]), e_bz);
            chk("bubble_cnt",  k, cnt_a[k], mcnt[k]);
            if (bump && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
        end
    end

    task automatic setin(input logic [4:0] a1, input logic [4:0] a2, input logic v1,
                         input logic v2, input logic [4:0] d, input logic m, input logic r);
        rs1 = a1; rs2 = a2; u1 = v1; u2 = v2; rd = d; mr = m; redir = r;
    endtask

    task automatic idle();
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic hazard();
        setin(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string nm, input int c0, input int c1, input int c2);
        chk(nm, 0, cnt_a[0], c0);
        chk(nm, 1, cnt_a[1], c1);
        chk(nm, 2, cnt_a[2], c2);
    endtask

    initial begin
        rstn = 1'b0;
        hazard();
        #1;
        // Hazard inputs present while in reset: everything must stay quiet.
        chk("rst_stall_pc", 0, int'(st_pc[0]), 0);
        chk("rst_flush_id_ex", 1, int'(fl_idex[1]), 0);
        tick(3);
        idle();
        rstn = 1'b1;
        tick(2);

        // lw x5 in EX, add x6,x5,x7 in ID.
        hazard();
        #1;
        chk("t1_stall", 0, int'(st_pc[0]), 1);
        chk("t1_busy", 0, int'(bz[0]), 0);
        tick(1);
        idle();
        #1;
        chk("t1_wait_busy", 1, int'(bz[1]), 1);
        chk("t1_l1_idle", 0, int'(st_pc[0]), 0);
        tick(4);
        chk_cnts("t1_cnt", 1, 3, 2);

        // x0 destination and an unused rs2 match never stall.
        setin(5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        #1;
        chk("x0_stall", 0, int'(st_pc[0]), 0);
        tick(1);
        setin(5'd6, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        chk("unused_rs2_stall", 1, int'(st_pc[1]), 0);
        tick(1);
        idle();
        tick(1);
        chk_cnts("t2_cnt", 1, 3, 2);

        // Redirect one cycle into a multi-cycle stall.
        hazard();
        tick(1);
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        chk("t3_flush_if_id", 1, int'(fl_ifid[1]), 1);
        chk("t3_flush_id_ex", 1, int'(fl_idex[1]), 1);
        chk("t3_stall", 1, int'(st_pc[1]), 0);
        tick(1);
        idle();
        #1;
        chk("t3_after_busy", 1, int'(bz[1]), 0);
        chk("t3_after_stall", 1, int'(st_pc[1]), 0);
        tick(3);
        chk_cnts("t3_cnt", 2, 4, 3);

        // Detect and redirect together: flush only.
        setin(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        #1;
        chk("t4_stall", 0, int'(st_pc[0]), 0);
        chk("t4_flush_if_id", 0, int'(fl_ifid[0]), 1);
        tick(1);
        idle();
        tick(2);
        chk_cnts("t4_cnt", 2, 4, 3);

        // Back-to-back hazards with no gap cycle.
        hazard();
        tick(6);
        idle();
        tick(4);
        chk_cnts("t5_cnt", 8, 10, 9);

        // Drive the 4-bit counter well past saturation.
        for (int i = 0; i < 17; i++) begin
            hazard();
            tick(1);
            idle();
            tick(3);
        end
        chk_cnts("t6_cnt", 25, 61, 15);

        // Async reset in the middle of a WAIT.
        hazard();
        tick(1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t7_stall", 2, int'(st_pc[2]), 0);
        chk("t7_flush_id_ex", 2, int'(fl_idex[2]), 0);
        chk("t7_busy", 2, int'(bz[2]), 0);
        chk_cnts("t7_cnt", 0, 0, 0);
        @(posedge clk);
        #1;
        idle();
        rstn = 1'b1;
        tick(2);
        hazard();
        tick(1);
        idle();
        tick(4);
        chk_cnts("t8_cnt", 1, 3, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core; next generation of the load-use detector.
- Detects load-use dependences between the ID-stage sources and an EX-stage load, ignoring x0 and unused sources.
- Supports data memories with multi-cycle load latency by holding the stall for a parameterised number of bubbles.
- Merges taken-branch/jump flush with stall control and keeps a saturating count of inserted bubbles; sits between the hazard inputs and the PC, IF/ID and ID/EX register enables.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, bubbles required per load-use hazard (>=1); 1 = classic single bubble.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- if_id_rs1  in  REG_AW  ID-stage source 1 address.
- if_id_rs2  in  REG_AW  ID-stage source 2 address.
- if_id_rs1_used  in  1  ID instruction reads rs1.
- if_id_rs2_used  in  1  ID instruction reads rs2.
- id_ex_rd  in  REG_AW  EX-stage destination address.
- id_ex_mem_read  in  1  EX-stage instruction is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID register.
- flush_if_id  out  1  clear IF/ID register to NOP.
- flush_id_ex  out  1  clear ID/EX register to NOP (bubble or redirect).
- busy  out  1  multi-cycle stall in progress.
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- detect = id_ex_mem_read && id_ex_rd!=0 && ((rs1_used && rd==rs1) || (rs2_used && rd==rs2)); combinational.
- Reset (rstn low, async): state IDLE, remaining=0, bubble_cnt=0. All stall/flush outputs and busy are 0 while rstn is low, regardless of inputs.
- FSM states: IDLE, WAIT. Down-counter remaining has width clog2(LOAD_LAT+1).
- IDLE, detect && !ex_redirect:
  - Same cycle: stall_pc=stall_if_id=flush_id_ex=1.
  - If LOAD_LAT>1: next state WAIT, remaining=LOAD_LAT-1. Otherwise stay in IDLE.
- WAIT: stall_pc=stall_if_id=flush_id_ex=1 and busy=1 every cycle; remaining decrements each cycle.
  - When remaining reaches 1, the cycle is still a stall; next state is IDLE.
  - Total bubbles per hazard = LOAD_LAT exactly.
  - The combinational detect is ignored in WAIT: ID/EX already holds a bubble, so it cannot re-trigger.
- ex_redirect=1 (any state): flush_if_id=flush_id_ex=1, stall_pc=stall_if_id=0.
  - Next state IDLE, remaining=0.
  - Redirect beats detect in the same cycle; no bubble is counted, because the consumer is being squashed.
- bubble_cnt increments by 1 in every cycle where a load-use bubble is inserted (IDLE-detect cycle or WAIT cycle, without redirect). It saturates at all-ones and never wraps.
- Back-to-back hazards: a new detect in the first IDLE cycle after WAIT starts a fresh sequence with no gap cycle.
- LOAD_LAT=1: WAIT is never entered; behaviour equals the single-bubble detector, plus x0/used gating and redirect.
- Outputs are combinational from state plus inputs; there is no registered output latency.

Decomposition:
- Shared package core_pkg holds:
  - REG_AW.
  - NOP encoding constant used by the flush consumers.
  - State enum localparams HZ_IDLE and HZ_WAIT.
- One natural sub-module: hazard_detect_cmp, the pure combinational dependence comparator. It is reused later by the forwarding unit.
- FSM and counter stay in the top module.

Test Plan:
- LOAD_LAT=1: lw x5 in EX, ID add x6,x5,x7 (rs1_used=1) -> one cycle with stall_pc=stall_if_id=flush_id_ex=1; bubble_cnt 0→1; busy stays 0.
- id_ex_rd=0 with rs1=0 used; separately rd=x5 matching rs2=x5 with rs2_used=0 -> no stall, bubble_cnt unchanged.
- LOAD_LAT=3: hazard at cycle t -> stall asserted t,t+1,t+2; busy=1 at t+1,t+2; idle at t+3; bubble_cnt +3.
- LOAD_LAT=3: ex_redirect at t+1 of a stall -> t+1 shows flush_if_id=flush_id_ex=1 with stalls=0; IDLE at t+2; bubble_cnt +1.
- detect and ex_redirect in the same cycle -> flush only, no stall, bubble_cnt unchanged.
- CNT_W=4: 17 single-bubble hazards -> bubble_cnt saturates at 15. Then rstn low mid-WAIT -> all outputs 0 immediately and bubble_cnt=0.
